spi_master: RTL and testbench
=============================

# spi_master

Byte-wide SPI master that drives the serial bus (`sclk`, `cs`, `mosi`) into the SPI slave and captures its `miso` response. Sits between the system-side controller, which issues one-byte transfer requests, and the slave. It supports all four `smode` settings with the same CPOL/CPHA meaning the slave uses. Each transfer is full-duplex and MSB-first.

## Interface
Parameters:
- `CLK_DIV`, 2: `clk` cycles per `sclk` half-period; legal range ≥1.
- `DATA_W`, 8: transfer width in bits.

Ports:
- `clk`  input  1  system clock; all logic is on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a transfer; sampled only in IDLE.
- `datain`  input  DATA_W  byte to transmit; latched when `start` is accepted.
- `smode`  input  2  SPI mode; latched when `start` is accepted. `smode[1]`=CPOL, `smode[0]`=CPHA.
- `dataout`  output  DATA_W  byte received on `miso`; updated at `done`.
- `busy`  output  1  transfer in progress.
- `done`  output  1  one-cycle pulse when the transfer completes.
- `sclk`  output  1  serial clock to the slave.
- `cs`  output  1  active-low chip select.
- `mosi`  output  1  serial data out.
- `miso`  input  1  serial data in; ignored while `cs`=1 (the slave floats it).

## Operation
- Reset values, applied asynchronously while `reset`=0: `cs`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `dataout`=0, FSM in IDLE, latched mode=0.
- FSM states:
  - IDLE: `sclk` = latched CPOL, `cs`=1. `start`=1 latches `datain` into the shift register and `smode` into the mode register, then goes to SETUP.
  - SETUP: `cs`=0 for one half-period. For CPHA=0, `mosi` = MSB from the first cycle of SETUP.
  - XFER: 2·DATA_W `sclk` edges, one per half-period, counted by edge index 0..2·DATA_W−1.
  - HOLD: `cs` stays 0 and `sclk` stays idle for one half-period.
  - DONE: `cs`=1, `done`=1, `dataout` ← shift register. Next state is IDLE.
- Edge roles:
  - Sample edges are rising edges for modes 0 and 3, falling edges for modes 1 and 2. The master samples `miso` into the shift register LSB on these edges.
  - Launch edges are the other edges. The master shifts left and drives the new MSB on `mosi` on these edges.
  - CPHA=0: even edge indices sample, odd indices launch; the last launch is suppressed.
  - CPHA=1: even indices launch (index 0 launches the MSB), odd indices sample.
- `busy` = (state ≠ IDLE). `start` while busy is ignored, not queued.
- `datain` and `smode` changes during a transfer have no effect.

## Timing
- `start` accepted at rising edge k. Then:
  - `cs` falls at k+1.
  - First `sclk` edge at k+1+CLK_DIV.
  - Last `sclk` edge at k+1+2·DATA_W·CLK_DIV.
  - `cs` rises, `done`=1 and `dataout` is valid at k+1+(2·DATA_W+2)·CLK_DIV. With defaults this is k+37.
- `busy` is high from k+1 through the `done` cycle inclusive. The next `start` can be accepted in the cycle after `done`.
- `sclk` has a 50% duty cycle with period 2·CLK_DIV `clk` cycles. `sclk` and `mosi` are registered outputs with no combinational path from inputs.
- Reset mid-transfer: the bus goes idle (`cs`=1) immediately, no `done` pulse is produced, and the partial byte is discarded.

## Configuration
- `SPI_MASTER_LOOPBACK_EN` defined: adds input port `loopback` (1 bit), sampled at `start`. When it is 1, sample edges capture the internal `mosi` instead of `miso`, and `dataout` equals the transmitted byte. Bus pins still toggle normally.
- Not defined: no `loopback` port; `miso` is always sampled.

## Structure
- Shared package `spi_pkg` holds:
  - FSM state enum (IDLE, SETUP, XFER, HOLD, DONE).
  - Mode constants `SPI_MODE0`..`SPI_MODE3`.
  - Default `DATA_W`.
  - Helper function for CPOL/CPHA decoding; the slave and master share it.
- Sub-module `spi_clkgen` contains the half-period divider. It produces a one-cycle `tick` every CLK_DIV cycles while enabled and is cleared when entering SETUP. The FSM, edge counter and shift register stay in `spi_master`.

## Test plan
- Mode 0, `datain`=8'h3C, slave model returns 8'hC3 → `mosi` stream 0011_1100 on rising edges, `dataout`=8'hC3, `done` exactly 37 cycles after `start`.
- Modes 1, 2 and 3 with `datain`=8'hA5 and slave reply 8'h5A:
  - `sclk` idles at CPOL before and after the transfer.
  - Sample edges and launch edges follow the rules in Operation.
  - `dataout`=8'h5A in each mode.
- `start` pulsed again at cycles k+5 and k+36 → ignored. At k+38 (cycle after `done`) → accepted, with `cs` falling at k+39.
- `reset` asserted at k+20 → `cs`=1, `sclk`=0, `busy`=0 immediately; no `done`; `dataout` stays 0.
- CLK_DIV=1, `datain`=8'hFF, `miso` tied 0 → `dataout`=8'h00, `done` at k+19, 16 `sclk` edges counted.
- With `SPI_MASTER_LOOPBACK_EN` defined, `loopback`=1, `datain`=8'h96, `miso` stuck 1 → `dataout`=8'h96.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI FSM states, mode constants and CPOL/CPHA decode.
// The master and the slave both import it.
package spi_pkg;
  localparam int SPI_DATA_W = 8;
  localparam logic [1:0] SPI_MODE0 = 2'd0;
  localparam logic [1:0] SPI_MODE1 = 2'd1;
  localparam logic [1:0] SPI_MODE2 = 2'd2;
  localparam logic [1:0] SPI_MODE3 = 2'd3;
  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} spi_state_e;
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_cfg_t;
  function automatic spi_cfg_t spi_decode(input logic [1:0] mode);
    return '{cpol: mode[1], cpha: mode[0]};
  endfunction
endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: sclk half-period divider.
// It emits a one-cycle tick every CLK_DIV enabled cycles and restarts on clr.
module spi_clkgen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(CLK_DIV - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else if (en) cnt <= cnt + CW'(1);
endmodule

// File: rtl/spi_master.sv
// spi_master: byte-wide full-duplex MSB-first SPI master supporting all four modes.
// Define SPI_MASTER_LOOPBACK_EN to add a loopback port that samples internal mosi instead of miso.
module spi_master import spi_pkg::*; #(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] datain,
  input  logic [1:0]        smode,
  output logic [DATA_W-1:0] dataout,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  input  logic              miso
`ifdef SPI_MASTER_LOOPBACK_EN
  , input logic            loopback
`endif
);
  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] LAST = EW'(2 * DATA_W);
  spi_state_e state, state_nx;
  spi_cfg_t cfg;
  logic [1:0] mode_q;
  logic [DATA_W-1:0] sr;
  logic [EW-1:0] edge_idx;
  logic tick, accept, edge_en, sample, launch, rx_bit;
  assign cfg = spi_decode(mode_q);
  assign accept = state == IDLE && start;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign cs = state == IDLE || state == DONE;
  // Edge 0 fires on the SETUP tick; XFER keeps toggling until all 2*DATA_W edges are out.
  assign edge_en = tick && (state == SETUP || (state == XFER && edge_idx != LAST));
  assign sample = edge_en && edge_idx[0] == cfg.cpha;
  assign launch = edge_en && !sample && !(!cfg.cpha && edge_idx == LAST - EW'(1));
`ifdef SPI_MASTER_LOOPBACK_EN
  logic lb_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) lb_q <= 1'b0;
    else if (accept) lb_q <= loopback;
  assign rx_bit = lb_q ? mosi : miso;
`else
  assign rx_bit = miso;
`endif
  spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk(clk),
    .reset(reset),
    .en(busy && !done),
    .clr(accept),
    .tick(tick)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = SETUP;
      SETUP:   if (tick) state_nx = XFER;
      XFER:    if (tick && edge_idx == LAST) state_nx = HOLD;
      HOLD:    if (tick) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  // mosi is a register holding the bit in flight, so sampled bits need not wait for a shift.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mode_q   <= '0;
      sr       <= '0;
      edge_idx <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      dataout  <= '0;
    end else begin
      if (state == IDLE) sclk <= cfg.cpol;
      if (accept) begin
        mode_q   <= smode;
        sr       <= datain;
        edge_idx <= '0;
        sclk     <= spi_decode(smode).cpol;
        mosi     <= datain[DATA_W-1];
      end
      if (edge_en) begin
        sclk     <= ~sclk;
        edge_idx <= edge_idx + EW'(1);
      end
      if (sample) sr <= {sr[DATA_W-2:0], rx_bit};
      if (launch) mosi <= sr[DATA_W-1];
      if (state == HOLD && tick) dataout <= sr;
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: table-driven and randomized checks of spi_master against a bench-side SPI slave.
// Two instances run side by side: CLK_DIV=2 (index 0) and CLK_DIV=1 (index 1).
module tb_spi_master;
  import spi_pkg::*;
  typedef struct {
    logic [1:0] m;
    logic [7:0] din;
    logic [7:0] rep;
    logic [7:0] exp_out;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_v[2], start_v[2], busy_v[2], done_v[2], sclk_v[2], cs_v[2], mosi_v[2], miso_v[2];
  logic [7:0] datain_v[2], dataout_v[2];
  logic [1:0] smode_v[2];
  logic [1:0] slv_mode[2];
  logic [7:0] reply[2], cap[2];
  int n_smp[2], edges[2], viol[2];
  logic prev_cs[2] = '{1'b1, 1'b1};
  logic prev_sclk[2] = '{1'b0, 1'b0};
  logic prev_mosi[2] = '{1'b0, 1'b0};
  int checks = 0, errors = 0;
  int div_of[2] = '{2, 1};
`ifdef SPI_MASTER_LOOPBACK_EN
  logic lb_v[2] = '{1'b0, 1'b0};
`endif

  spi_master #(.CLK_DIV(2), .DATA_W(8)) u0 (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .datain(datain_v[0]), .smode(smode_v[0]),
    .dataout(dataout_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sclk(sclk_v[0]), .cs(cs_v[0]),
    .mosi(mosi_v[0]), .miso(miso_v[0])
`ifdef SPI_MASTER_LOOPBACK_EN
    , .loopback(lb_v[0])
`endif
  );
  spi_master #(.CLK_DIV(1), .DATA_W(8)) u1 (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .datain(datain_v[1]), .smode(smode_v[1]),
    .dataout(dataout_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sclk(sclk_v[1]), .cs(cs_v[1]),
    .mosi(mosi_v[1]), .miso(miso_v[1])
`ifdef SPI_MASTER_LOOPBACK_EN
    , .loopback(lb_v[1])
`endif
  );

  // Slave model: sample edges are rising in modes 0/3, falling in 1/2; it presents the reply MSB
  // on cs fall and moves to the next reply bit after each sample edge.
  always @(negedge clk)
    for (int d = 0; d < 2; d++) begin
      if (prev_cs[d] && !cs_v[d]) begin
        n_smp[d] = 0;
        edges[d] = 0;
        viol[d] = 0;
        cap[d] = '0;
        miso_v[d] = reply[d][7];
      end else if (cs_v[d]) miso_v[d] = 1'($urandom);
      else if (sclk_v[d] != prev_sclk[d]) begin
        edges[d]++;
        if (sclk_v[d] == (slv_mode[d] == SPI_MODE0 || slv_mode[d] == SPI_MODE3)) begin
          if (mosi_v[d] != prev_mosi[d]) viol[d]++;
          cap[d] = {cap[d][6:0], mosi_v[d]};
          n_smp[d]++;
          miso_v[d] = n_smp[d] < 8 ? reply[d][7 - n_smp[d]] : 1'b0;
        end
      end
      prev_cs[d] = cs_v[d];
      prev_sclk[d] = sclk_v[d];
      prev_mosi[d] = mosi_v[d];
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_xfer(input int d, input logic [1:0] m, input logic [7:0] din, input logic [7:0] rep,
                          input logic [7:0] exp_out, input logic poke, input string tag);
    int cyc = 0;
    int exp_cyc = 1 + (2 * 8 + 2) * div_of[d];
    slv_mode[d] = m;
    reply[d] = rep;
    @(negedge clk);
    chk({tag, " idle busy/done/cs"}, 32'({busy_v[d], done_v[d], cs_v[d]}), 32'(3'b001));
    datain_v[d] = din;
    smode_v[d] = m;
    start_v[d] = 1'b1;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    datain_v[d] = 8'($urandom);
    smode_v[d] = 2'($urandom);
    do begin
      @(negedge clk);
      cyc++;
      start_v[d] = poke && (cyc == 5 || cyc == 36);
      if (cyc == 1) begin
        chk({tag, " setup cs/sclk/busy"}, 32'({cs_v[d], sclk_v[d], busy_v[d]}), 32'({1'b0, m[1], 1'b1}));
        if (!m[0]) chk({tag, " setup mosi msb"}, 32'(mosi_v[d]), 32'(din[7]));
      end
    end while (!done_v[d] && cyc < 200);
    start_v[d] = 1'b0;
    chk({tag, " done latency"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, " dataout"}, 32'(dataout_v[d]), 32'(exp_out));
    chk({tag, " mosi stream"}, 32'(cap[d]), 32'(din));
    chk({tag, " sclk edges"}, 32'(edges[d]), 32'(16));
    chk({tag, " mosi moved on sample edge"}, 32'(viol[d]), 32'(0));
    chk({tag, " done cs/sclk/busy"}, 32'({cs_v[d], sclk_v[d], busy_v[d]}), 32'({1'b1, m[1], 1'b1}));
  endtask

  initial begin
    vec_t tbl[4];
    int ndone;
    tbl[0] = '{SPI_MODE0, 8'h3C, 8'hC3, 8'hC3};
    tbl[1] = '{SPI_MODE1, 8'hA5, 8'h5A, 8'h5A};
    tbl[2] = '{SPI_MODE2, 8'hA5, 8'h5A, 8'h5A};
    tbl[3] = '{SPI_MODE3, 8'hA5, 8'h5A, 8'h5A};
    for (int d = 0; d < 2; d++) begin
      rst_v[d] = 1'b0;
      start_v[d] = 1'b0;
      datain_v[d] = '0;
      smode_v[d] = '0;
      slv_mode[d] = SPI_MODE0;
      reply[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset cs/sclk/mosi/busy/done", 32'({cs_v[d], sclk_v[d], mosi_v[d], busy_v[d], done_v[d]}), 32'(5'b10000));
      chk("reset dataout", 32'(dataout_v[d]), 32'(0));
    end
    rst_v[0] = 1'b1;
    rst_v[1] = 1'b1;

    for (int i = 0; i < 4; i++)
      run_xfer(0, tbl[i].m, tbl[i].din, tbl[i].rep, tbl[i].exp_out, 1'b0, $sformatf("tbl%0d", i));

    // Starts at k+5 and k+36 are ignored; a start in the cycle after done is taken.
    run_xfer(0, SPI_MODE0, 8'h3C, 8'hC3, 8'hC3, 1'b1, "ignore");
    run_xfer(0, SPI_MODE0, 8'h81, 8'h7E, 8'h7E, 1'b0, "chain");

    // Reset in the middle of a transfer.
    slv_mode[0] = SPI_MODE2;
    reply[0] = 8'h99;
    @(negedge clk);
    datain_v[0] = 8'h55;
    smode_v[0] = SPI_MODE2;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (19) @(negedge clk);
    rst_v[0] = 1'b0;
    #1;
    chk("midreset cs/sclk/busy", 32'({cs_v[0], sclk_v[0], busy_v[0]}), 32'(3'b100));
    repeat (2) @(negedge clk);
    rst_v[0] = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    chk("midreset done pulses", 32'(ndone), 32'(0));
    chk("midreset dataout", 32'(dataout_v[0]), 32'(0));

    run_xfer(1, SPI_MODE0, 8'hFF, 8'h00, 8'h00, 1'b0, "div1");

    for (int i = 0; i < 12; i++) begin
      logic [7:0] din = 8'($urandom);
      logic [7:0] rep = 8'($urandom);
      run_xfer(i % 2, 2'($urandom_range(0, 3)), din, rep, rep, 1'b0, $sformatf("rnd%0d", i));
    end

`ifdef SPI_MASTER_LOOPBACK_EN
    lb_v[0] = 1'b1;
    run_xfer(0, SPI_MODE0, 8'h96, 8'hFF, 8'h96, 1'b0, "loopback m0");
    run_xfer(0, SPI_MODE3, 8'h96, 8'hFF, 8'h96, 1'b0, "loopback m3");
    lb_v[0] = 1'b0;
    run_xfer(0, SPI_MODE0, 8'h96, 8'hFF, 8'hFF, 1'b0, "loopback off");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
